// File: rtl/t08_mem_responder.sv
// ---------------------------------------------------------------------------
// t08_mem_responder
//
// Word-organised data memory that answers a load/store handler with a fixed,
// parameterised latency. A request sampled in IDLE is latched in full, the
// block stays busy for LATENCY+1 cycles, and a one-cycle done pulse (with
// error status) marks completion. Storage and rdata update on the edge that
// enters RESP, so they are visible together with done.
//
// Parameters
//   DEPTH    number of 32-bit words in storage (default 64)
//   LATENCY  cycles from accept to done, 1..15 (default 2)
//
// Ports
//   clk      in   system clock, rising edge
//   nrst     in   asynchronous active-low reset
//   read     in   read request
//   write    in   write request
//   address  in   byte address; word index is address[31:2]
//   wdata    in   write data
//   wstrb    in   byte-lane write enables (bit i -> wdata[8i+7:8i])
//   rdata    out  last successfully read word
//   busy     out  transaction in progress (WAIT or RESP)
//   done     out  one-cycle completion pulse
//   error    out  completion status, only meaningful while done=1
// ---------------------------------------------------------------------------
module t08_mem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_accept;
    logic        w_finish;

    // Request captured at accept; inputs are don't-care afterwards.
    logic [29:0] r_widx;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_rd;
    logic        r_wr;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_err;

    logic          w_oob;
    logic          w_err;
    logic          w_do_wr;
    logic          w_do_rd;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    // Alignment is the handler's job; the low address bits carry no meaning here.
    assign w_unused_addr = ^address[1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state / counter
    // The counter starts at 1 on accept, so a LATENCY=1 transaction spends
    // exactly one cycle in WAIT and done lands at accept+LATENCY for every
    // legal LATENCY.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (read || write) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 4'd1;
                end
            end
            S_WAIT: begin
                if (r_cnt == LAT) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_RESP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_widx  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else if (w_accept) begin
            r_widx  <= address[31:2];
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            r_rd    <= read;
            r_wr    <= write;
        end
    end

    // ------------------------------------------------------------------
    // Completion decode
    // ------------------------------------------------------------------
    assign w_oob   = ({2'b00, r_widx} >= 32'(DEPTH));
    assign w_err   = (r_rd && r_wr) || w_oob;
    assign w_do_wr = w_finish && r_wr && !w_err;
    assign w_do_rd = w_finish && r_rd && !w_err;
    assign w_idx   = r_widx[AW-1:0];

    // ------------------------------------------------------------------
    // Storage: byte-lane merge on the edge entering RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response registers; rdata only moves on a successful read
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_err  <= w_finish && w_err;
            if (w_do_rd) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    assign rdata = r_rdata;
    assign done  = r_done;
    assign error = r_err;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_t08_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_t08_mem_responder
//
// Scoreboard bench. The driver computes each request's expected outcome from
// a word-array reference model at issue time and queues it with the cycle on
// which done must appear; a separate monitor checks busy, done, error and
// rdata every falling edge. A second instance at LATENCY=1 covers the
// held-read throughput case.
// ---------------------------------------------------------------------------
module tb_t08_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;

    typedef struct {
        int unsigned done_cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        nrst;

    // main instance (LATENCY=2)
    logic        read, write;
    logic [31:0] address, wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        busy, done, error;

    // throughput instance (LATENCY=1)
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  s1;
    logic [31:0] rdata1;
    logic        busy1, done1, error1;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    exp_t        sb[$];
    int unsigned busy_lo = 1;
    int unsigned busy_hi = 0;
    int unsigned next_ok = 0;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_rdata;

    t08_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .nrst(nrst), .read(read), .write(write),
        .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .busy(busy), .done(done), .error(error)
    );

    t08_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .nrst(nrst), .read(r1), .write(w1),
        .address(a1), .wdata(d1), .wstrb(s1),
        .rdata(rdata1), .busy(busy1), .done(done1), .error(error1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
        mdl_rdata = '0;
    endtask

    // Issue one request at the earliest legal edge. While the DUT is still
    // busy the inputs are either held at the upcoming request or scrambled;
    // either way they must be ignored.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb, input bit hold);
        exp_t        e;
        logic [29:0] widx;
        logic [31:0] mask;
        logic        err;
        int unsigned acc;
        @(negedge clk);
        while (cyc + 1 < next_ok) begin
            if (hold) begin
                read = rd; write = wr; address = addr; wdata = data; wstrb = strb;
            end else begin
                read    = 1'($urandom_range(0, 1));
                write   = 1'($urandom_range(0, 1));
                address = $urandom;
                wdata   = $urandom;
                wstrb   = 4'($urandom);
            end
            @(negedge clk);
        end
        read = rd; write = wr; address = addr; wdata = data; wstrb = strb;
        acc  = cyc + 1;

        widx = addr[31:2];
        err  = (rd && wr) || (32'(widx) >= DEPTH);
        if (!err && wr) begin
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            mdl_mem[widx] = (mdl_mem[widx] & ~mask) | (data & mask);
        end
        if (!err && rd) mdl_rdata = mdl_mem[widx];
        e.done_cyc = acc + LAT;
        e.rdata    = mdl_rdata;
        e.err      = err;
        sb.push_back(e);
        busy_lo = acc;
        busy_hi = acc + LAT;
        next_ok = acc + LAT + 2;

        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    // Monitor: compares against the queue whenever done is presented.
    exp_t mon_e;
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("rdata", rdata, mon_e.rdata);
                chk("error", 32'(error), 32'(mon_e.err));
            end
        end else begin
            chk("error_without_done", 32'(error), 32'd0);
            if (sb.size() > 0 && cyc >= sb[0].done_cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_done actual=0 required=1 cyc=%0d", cyc);
                void'(sb.pop_front());
            end
        end
    end

    logic [31:0] v1;
    int unsigned a1_acc;
    int unsigned b_acc;
    logic [29:0] rw;
    logic        rrd, rwr;
    logic [31:0] raddr;

    initial begin
        nrst = 1'b0;
        read = 1'b0; write = 1'b0; address = '0; wdata = '0; wstrb = '0;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0; s1 = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        // release alone must not start anything (monitor sees busy=0, no done)
        repeat (3) @(negedge clk);

        // ---- held reads at LATENCY=1: period of three cycles ----
        v1 = $urandom;
        w1 = 1'b1; a1 = 32'h14; d1 = v1; s1 = 4'hF;
        a1_acc = cyc + 1;
        @(posedge clk);
        #1;
        w1 = 1'b0;
        @(negedge clk);
        while (cyc + 1 < a1_acc + 3) @(negedge clk);
        r1 = 1'b1;
        b_acc = cyc + 1;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            chk("l1_done", 32'(done1), 32'((cyc - b_acc) % 3 == 1));
            chk("l1_busy", 32'(busy1), 32'((cyc - b_acc) % 3 != 2));
            chk("l1_error", 32'(error1), 32'd0);
            if ((cyc - b_acc) % 3 == 1) chk("l1_rdata", rdata1, v1);
        end
        r1 = 1'b0;

        // ---- directed cases on the LATENCY=2 instance ----
        issue(1'b0, 1'b1, 32'h0000000C, 32'h7FFFFFFF, 4'hF, 1'b0);
        issue(1'b1, 1'b0, 32'h0000000C, 32'h0, 4'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h0000000C, 32'h000000AA, 4'h1, 1'b0);
        issue(1'b0, 1'b1, 32'h0000000C, 32'h0000BB00, 4'h2, 1'b1);
        issue(1'b1, 1'b0, 32'h0000000E, $urandom, 4'($urandom), 1'b0);
        issue(1'b1, 1'b0, 32'h00000100, 32'h0, 4'h0, 1'b0);
        issue(1'b1, 1'b1, 32'h0000000C, 32'h12345678, 4'hF, 1'b0);
        issue(1'b1, 1'b0, 32'h0000000C, 32'h0, 4'h0, 1'b1);
        issue(1'b0, 1'b1, 32'h0000000C, 32'hFFFFFFFF, 4'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h000000FC, 32'hA5A55A5A, 4'hF, 1'b0);
        issue(1'b0, 1'b1, 32'h00000100, 32'h11111111, 4'hF, 1'b0);
        issue(1'b1, 1'b0, 32'h000000FD, 32'h0, 4'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h0000000C, 32'h0, 4'h0, 1'b0);

        // ---- reset while a write to 0x10 sits in WAIT ----
        issue(1'b0, 1'b1, 32'h00000010, 32'hDEADBEEF, 4'hF, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        sb.delete();
        busy_lo = 1; busy_hi = 0; next_ok = 0;
        model_reset();
        @(posedge clk);
        #2;
        nrst = 1'b1;
        issue(1'b1, 1'b0, 32'h00000010, 32'h0, 4'h0, 1'b0);

        // ---- randomized traffic ----
        for (int n = 0; n < 80; n++) begin
            rw = 30'($urandom_range(0, DEPTH + 3));
            raddr = {rw, 2'($urandom)};
            if ($urandom_range(0, 15) == 0) raddr = $urandom;
            case ($urandom_range(0, 9))
                0:       begin rrd = 1'b1; rwr = 1'b1; end
                1, 2, 3, 4: begin rrd = 1'b1; rwr = 1'b0; end
                default: begin rrd = 1'b0; rwr = 1'b1; end
            endcase
            issue(rrd, rwr, raddr, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
        end

        // ---- drain the scoreboard, bounded ----
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
